// File: rtl/dice_led_driver.sv
// rtl/dice_led_driver.sv - dice face LED driver: steady show, blink-out, blank; optional PWM dimming via DICE_LED_PWM_EN
module dice_led_driver #(
    parameter int TICK_DIV    = 1250000,
    parameter int HOLD_TICKS  = 500,
    parameter int BLINK_TICKS = 25,
    parameter int BLINK_COUNT = 6
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       LOAD,
    input  logic [2:0] VALUE,
    input  logic       CLEAR,
    input  logic [3:0] DUTY,
    output logic [6:0] LED,
    output logic       BUSY,
    output logic       ERR
);

    localparam int SEG_MAX = (HOLD_TICKS > BLINK_TICKS) ? HOLD_TICKS : BLINK_TICKS;
    localparam int TW = $clog2(TICK_DIV > 1 ? TICK_DIV : 2);
    localparam int SW = $clog2(SEG_MAX > 1 ? SEG_MAX : 2);
    localparam int PW = $clog2(BLINK_COUNT > 1 ? BLINK_COUNT : 2);
    localparam logic [TW-1:0] TICK_LAST  = TW'(TICK_DIV - 1);
    localparam logic [SW-1:0] HOLD_LAST  = SW'(HOLD_TICKS - 1);
    localparam logic [SW-1:0] BLINK_LAST = SW'(BLINK_TICKS - 1);
    localparam logic [PW-1:0] PHASE_LAST = PW'(BLINK_COUNT - 1);

    typedef enum logic [1:0] {S_IDLE, S_SHOW, S_BLINK} state_t;

    state_t        state_q, state_d;
    logic [TW-1:0] tick_q, tick_d;
    logic [SW-1:0] seg_q, seg_d;
    logic [PW-1:0] phase_q, phase_d;
    logic [6:0]    pat_q, pat_d;
    logic [6:0]    led_q, led_d;
    logic          busy_q, busy_d;
    logic          err_q, err_d;
    logic [6:0]    face;
    logic          load_ok;
    logic          tick;
    logic          lit;
    logic          pwm_on;

    // Invalid faces map to an all-zero pattern, which doubles as the validity test.
    function automatic logic [6:0] face_pattern(input logic [2:0] v);
        case (v)
            3'd1:    face_pattern = 7'b0001000;
            3'd2:    face_pattern = 7'b1000001;
            3'd3:    face_pattern = 7'b1001001;
            3'd4:    face_pattern = 7'b1100011;
            3'd5:    face_pattern = 7'b1101011;
            3'd6:    face_pattern = 7'b1110111;
            default: face_pattern = 7'b0000000;
        endcase
    endfunction

`ifdef DICE_LED_PWM_EN
    logic [3:0] pwm_q, pwm_d;

    assign pwm_d  = pwm_q + 4'd1;
    assign pwm_on = (pwm_d <= DUTY);

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) pwm_q <= 4'd0;
        else      pwm_q <= pwm_d;
    end
`else
    logic unused_duty;

    assign unused_duty = ^DUTY;
    assign pwm_on      = 1'b1;
`endif

    always_comb begin
        face    = face_pattern(VALUE);
        load_ok = LOAD && (face != 7'd0);
        tick    = (tick_q == TICK_LAST);
        state_d = state_q;
        tick_d  = tick_q;
        seg_d   = seg_q;
        phase_d = phase_q;
        pat_d   = pat_q;
        err_d   = 1'b0;
        if (CLEAR) begin
            state_d = S_IDLE;
            tick_d  = '0;
            seg_d   = '0;
            phase_d = '0;
            pat_d   = '0;
        end else if (load_ok) begin
            state_d = S_SHOW;
            pat_d   = face;
            tick_d  = '0;
            seg_d   = '0;
            phase_d = '0;
        end else begin
            err_d = LOAD;
            if (state_q != S_IDLE) begin
                tick_d = tick ? '0 : tick_q + 1'b1;
                if (tick && state_q == S_SHOW) begin
                    if (seg_q == HOLD_LAST) begin
                        state_d = S_BLINK;
                        seg_d   = '0;
                        phase_d = '0;
                    end else begin
                        seg_d = seg_q + 1'b1;
                    end
                end else if (tick) begin
                    if (seg_q != BLINK_LAST) begin
                        seg_d = seg_q + 1'b1;
                    end else if (phase_q == PHASE_LAST) begin
                        state_d = S_IDLE;
                        tick_d  = '0;
                        seg_d   = '0;
                        phase_d = '0;
                        pat_d   = '0;
                    end else begin
                        seg_d   = '0;
                        phase_d = phase_q + 1'b1;
                    end
                end
            end
        end
        // Even blink phases are dark, so BLINK always opens with the LEDs off.
        lit    = (state_d == S_SHOW) || (state_d == S_BLINK && phase_d[0]);
        led_d  = (lit && pwm_on) ? pat_d : 7'd0;
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q <= S_IDLE;
            tick_q  <= '0;
            seg_q   <= '0;
            phase_q <= '0;
            pat_q   <= '0;
            led_q   <= '0;
            busy_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            tick_q  <= tick_d;
            seg_q   <= seg_d;
            phase_q <= phase_d;
            pat_q   <= pat_d;
            led_q   <= led_d;
            busy_q  <= busy_d;
            err_q   <= err_d;
        end
    end

    assign LED  = led_q;
    assign BUSY = busy_q;
    assign ERR  = err_q;

endmodule

// File: tb/tb_dice_led_driver.sv
// tb/tb_dice_led_driver.sv - self-checking bench for dice_led_driver against a timeline reference model
module tb_dice_led_driver;

    localparam int TICK_DIV    = 4;
    localparam int HOLD_TICKS  = 3;
    localparam int BLINK_TICKS = 2;
    localparam int BLINK_COUNT = 4;
    localparam int SHOW_CYC    = HOLD_TICKS * TICK_DIV;
    localparam int HALF_CYC    = BLINK_TICKS * TICK_DIV;
    localparam int TOTAL_CYC   = SHOW_CYC + BLINK_COUNT * HALF_CYC;

    logic       CLK = 1'b0;
    logic       RST = 1'b0;
    logic       LOAD = 1'b0;
    logic [2:0] VALUE = 3'd0;
    logic       CLEAR = 1'b0;
    logic [3:0] DUTY = 4'd15;
    logic [6:0] LED;
    logic       BUSY;
    logic       ERR;

    int n_checks = 0;
    int n_fail   = 0;

    logic [6:0] faces [0:7];
    bit         m_active;
    logic [6:0] m_face;
    int         m_el;
    bit         m_err;

    dice_led_driver #(
        .TICK_DIV(TICK_DIV), .HOLD_TICKS(HOLD_TICKS),
        .BLINK_TICKS(BLINK_TICKS), .BLINK_COUNT(BLINK_COUNT)
    ) dut (
        .CLK(CLK), .RST(RST), .LOAD(LOAD), .VALUE(VALUE), .CLEAR(CLEAR),
        .DUTY(DUTY), .LED(LED), .BUSY(BUSY), .ERR(ERR)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_active = 0;
        m_el     = 0;
        m_err    = 0;
        m_face   = 7'd0;
    endtask

    task automatic model_update(input logic ld, input logic [2:0] v, input logic clr);
        m_err = 0;
        if (clr) begin
            m_active = 0;
        end else if (ld && v != 3'd0 && v != 3'd7) begin
            m_active = 1;
            m_face   = faces[v];
            m_el     = 0;
        end else begin
            m_err = ld;
            if (m_active) begin
                m_el++;
                if (m_el >= TOTAL_CYC) m_active = 0;
            end
        end
    endtask

    function automatic logic [6:0] model_led();
        if (!m_active)          return 7'd0;
        if (m_el < SHOW_CYC)    return m_face;
        if (((m_el - SHOW_CYC) / HALF_CYC) % 2 == 1) return m_face;
        return 7'd0;
    endfunction

    task automatic step(input logic ld, input logic [2:0] v, input logic clr);
        @(negedge CLK);
        LOAD = ld; VALUE = v; CLEAR = clr;
        @(posedge CLK);
        model_update(ld, v, clr);
        #1;
        check("led", LED, model_led());
        check("busy", BUSY, m_active);
        check("err", ERR, m_err);
    endtask

    task automatic idle_steps(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 3'd0, 1'b0);
    endtask

    initial begin
        faces[0] = 7'b0000000; faces[1] = 7'b0001000; faces[2] = 7'b1000001;
        faces[3] = 7'b1001001; faces[4] = 7'b1100011; faces[5] = 7'b1101011;
        faces[6] = 7'b1110111; faces[7] = 7'b0000000;
        model_reset();

        repeat (3) @(posedge CLK);
        #1;
        check("rst_led", LED, 7'd0);
        check("rst_busy", BUSY, 1'b0);
        check("rst_err", ERR, 1'b0);
        @(negedge CLK);
        RST = 1'b1;

        // Full show / blink / blank sequence for face 5.
        step(1'b1, 3'd5, 1'b0);
        check("load5_led", LED, 7'b1101011);
        check("load5_busy", BUSY, 1'b1);
        idle_steps(TOTAL_CYC + 4);
        check("end_led", LED, 7'd0);
        check("end_busy", BUSY, 1'b0);

        // Invalid loads in IDLE and mid-SHOW.
        step(1'b1, 3'd7, 1'b0);
        check("err_idle", ERR, 1'b1);
        idle_steps(2);
        step(1'b1, 3'd2, 1'b0);
        idle_steps(4);
        step(1'b1, 3'd0, 1'b0);
        check("err_show_led", LED, 7'b1000001);
        idle_steps(TOTAL_CYC);

        // Reload 6 at SHOW cycle 7 restarts a full SHOW.
        step(1'b1, 3'd3, 1'b0);
        idle_steps(6);
        step(1'b1, 3'd6, 1'b0);
        check("reload_led", LED, 7'b1110111);
        idle_steps(SHOW_CYC - 1);
        check("reload_show_end", LED, 7'b1110111);
        step(1'b0, 3'd0, 1'b0);
        check("reload_blink_off", LED, 7'd0);
        idle_steps(TOTAL_CYC);

        // CLEAR beats LOAD during BLINK.
        step(1'b1, 3'd4, 1'b0);
        idle_steps(SHOW_CYC + HALF_CYC + 2);
        step(1'b1, 3'd2, 1'b1);
        check("clr_led", LED, 7'd0);
        check("clr_err", ERR, 1'b0);
        idle_steps(3);

        // Asynchronous reset during an on-phase of BLINK.
        step(1'b1, 3'd5, 1'b0);
        idle_steps(SHOW_CYC + HALF_CYC + 2);
        check("pre_arst_led", LED, 7'b1101011);
        #3;
        RST = 1'b0;
        #1;
        check("arst_led", LED, 7'd0);
        check("arst_busy", BUSY, 1'b0);
        model_reset();
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        RST = 1'b1;
        idle_steps(TOTAL_CYC);
        step(1'b1, 3'd1, 1'b0);
        check("post_arst_load", LED, 7'b0001000);

        // Randomised traffic against the reference model.
        for (int i = 0; i < 3000; i++) begin
            logic ld, clr;
            ld  = ($urandom_range(0, 29) == 0);
            clr = ($urandom_range(0, 79) == 0);
            step(ld, 3'($urandom_range(0, 7)), clr);
        end

`ifdef DICE_LED_PWM_EN
        begin
            int on_cnt;
            DUTY = 4'd3;
            on_cnt = 0;
            for (int i = 0; i < 32; i++) begin
                @(negedge CLK);
                LOAD = (i % 8 == 0); VALUE = 3'd1; CLEAR = 1'b0;
                @(posedge CLK);
                #1;
                if (i >= 16 && LED[3]) on_cnt++;
            end
            check("pwm_duty3", on_cnt, 4);
            DUTY = 4'd15;
            on_cnt = 0;
            for (int i = 0; i < 16; i++) begin
                @(negedge CLK);
                LOAD = (i % 8 == 0); VALUE = 3'd1; CLEAR = 1'b0;
                @(posedge CLK);
                #1;
                if (LED[3]) on_cnt++;
            end
            check("pwm_duty15", on_cnt, 16);
            step(1'b0, 3'd0, 1'b1);
        end
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
